branch_pc_unit: RTL and testbench
=================================

# branch_pc_unit

Parametrised fetch-PC and branch unit for the pipelined processor. Holds the program counter, predicts conditional and unconditional branches at fetch with a direct-mapped table of 2-bit counters plus targets, and resolves branches from execute against the CPSR flags. On a wrong direction it redirects the PC and flushes the younger pipeline stages.

## Interface
- `mbus`, 32: address/PC width.
- `ENTRIES`, 16: predictor entries; power of two, ≥2; `IDXW = log2(ENTRIES)`.
- `RESET_PC`, 0: PC value after reset.
- `MCNTW`, 16: width of the mispredict counter.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `stall`  in  1  hold the PC this cycle.
- `pc`  out  mbus  current fetch PC, registered.
- `predTaken`  out  1  prediction for `pc`, combinational.
- `exValid`  in  1  a branch resolves in execute this cycle.
- `exPC`  in  mbus  PC of the resolving branch.
- `exTarget`  in  mbus  branch target address.
- `exCond`  in  3  condition code.
- `exPredTaken`  in  1  prediction that was made for this branch at fetch.
- `CPSR`  in  4  flags: [0]=Z, [1]=N, [2]=C, [3]=V.
- `flush`  out  1  mispredict pulse, combinational.
- `mispredictCount`  out  MCNTW  saturating mispredict count.

## Operation
- Conditions: 000 AL, 001 EQ (Z), 010 NE (!Z), 011 LT (N≠V), 100 GE (N=V), 101 CS (C); 110/111 reserved, never taken.
- `taken = exValid && cond(exCond, CPSR)`. `mispredict = exValid && (taken != exPredTaken)`. `flush = mispredict`.
- Table lookup: `idx = pc[IDXW+1:2]`, `tag = pc[mbus-1:IDXW+2]`. `predTaken = valid[idx] && tag match && ctr[idx][1]`. A predicted target comes from the table.
- Next-PC priority:
  1. Mispredict: `taken ? exTarget : exPC+4`. This wins over `stall`.
  2. `stall`: hold.
  3. `predTaken`: the stored target.
  4. Otherwise `pc+4`, wrapping modulo 2^mbus.
- Table update on `exValid`, indexed by `exPC`:
  - Tag hit: counter increments on taken, decrements on not-taken, saturating at 3 and 0.
  - Taken with a tag hit: target is rewritten with `exTarget`.
  - Taken with a tag miss or invalid entry: allocate. Set valid, tag, target, counter = 2'b10.
  - Not-taken with a tag miss: no change.
- Targets are direct, so direction mispredict is the only mispredict class.
- `mispredictCount` increments by 1 on each mispredict and holds at all-ones.

## Timing
- Reset (asynchronous, immediate):
  - `pc` = RESET_PC.
  - All valid bits = 0; counters = 2'b01.
  - `mispredictCount` = 0.
  - Consequently `predTaken` = 0 and `flush` = `mispredict` (inputs only).
- Latency:
  - `pc` updates one edge after the next-PC decision.
  - `flush` is asserted in the same cycle as `exValid`. The corrected `pc` is visible after the following edge.
- Same-cycle lookup and update of one index: the lookup sees pre-update state; the update is visible next cycle.
- `exValid` with `stall` and no mispredict: the table updates and the PC holds.
- Reset asserted mid-operation: all state returns to reset values at once, with no partial update. Deassertion is synchronised externally.

## Configuration
- `BRANCH_PREDICT_EN` defined:
  - Predictor table is present, as described above.
- `BRANCH_PREDICT_EN` undefined:
  - No table storage.
  - `predTaken` is tied to 0, so the default next PC is `pc+4`.
  - `mispredict = taken`, since the branch is assumed to arrive with `exPredTaken` = 0.
  - Redirect, `flush` and `mispredictCount` behave as above.

## Test plan
- **Reset:** assert `rst` mid-run, RESET_PC=0x100 → `pc`=0x100 immediately, `predTaken`=0, `mispredictCount`=0; after release, `pc` goes 0x104, 0x108.
- **Cold BEQ:** exValid, exPC=0x20, exTarget=0x80, exCond=001, Z=1, exPredTaken=0 → `flush`=1 that cycle; next `pc`=0x80; count=1; entry 8 allocated with ctr=2.
- **Warm BEQ:** fetch `pc`=0x20 again → `predTaken`=1 and next `pc`=0x80. Resolve with Z=0, exPredTaken=1 → `flush`, next `pc`=0x24, ctr drops to 1. Next fetch of 0x20 → `predTaken`=0.
- **Stall vs. mispredict:** `stall`=1 alone → `pc` holds. `stall`=1 with a mispredict (NE, Z=0, target 0x200, predicted 0) → next `pc`=0x200.
- **Conditions and saturation:**
  - LT with N=1, V=0 → taken. GE with N=1, V=1 → taken.
  - Code 111 → not taken, and no table allocation.
  - Counter saturates at 3 after four taken resolutions.
  - With MCNTW=2, four mispredicts → `mispredictCount`=3.
- **Macro off:** same stimulus as cold BEQ → identical redirect. `predTaken` stays 0 throughout and `pc` wraps 0xFFFFFFFC → 0x0.

Source files
------------

// File: rtl/branch_pc_unit.sv
// Fetch PC register with execute-stage branch resolution, redirect/flush and a saturating mispredict count.
// Define BRANCH_PREDICT_EN to add the direct-mapped 2-bit-counter predictor table at fetch.
module branch_pc_unit #(
  parameter int              mbus     = 32,
  parameter int              ENTRIES  = 16,
  parameter logic [mbus-1:0] RESET_PC = '0,
  parameter int              MCNTW    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  output logic [mbus-1:0]  pc,
  output logic             predTaken,
  input  logic             exValid,
  input  logic [mbus-1:0]  exPC,
  input  logic [mbus-1:0]  exTarget,
  input  logic [2:0]       exCond,
  input  logic             exPredTaken,
  input  logic [3:0]       CPSR,
  output logic             flush,
  output logic [MCNTW-1:0] mispredictCount
);
  localparam int              IDXW = $clog2(ENTRIES);
  localparam int              TAGW = mbus - IDXW - 2;
  localparam logic [mbus-1:0] FOUR = mbus'(4);

  logic            cond_true;
  logic            taken;
  logic            mispredict;
  logic [mbus-1:0] pred_target;
  logic [mbus-1:0] next_pc;

  // CPSR layout: [0]=Z, [1]=N, [2]=C, [3]=V; codes 110/111 are reserved and never taken
  always_comb begin
    case (exCond)
      3'b000:  cond_true = 1'b1;
      3'b001:  cond_true = CPSR[0];
      3'b010:  cond_true = !CPSR[0];
      3'b011:  cond_true = (CPSR[1] != CPSR[3]);
      3'b100:  cond_true = (CPSR[1] == CPSR[3]);
      3'b101:  cond_true = CPSR[2];
      default: cond_true = 1'b0;
    endcase
  end

  assign taken = exValid && cond_true;
  assign flush = mispredict;

`ifdef BRANCH_PREDICT_EN
  logic [ENTRIES-1:0] valid;
  logic [1:0]         ctr        [ENTRIES];
  logic [TAGW-1:0]    tag_mem    [ENTRIES];
  logic [mbus-1:0]    target_mem [ENTRIES];
  logic [IDXW-1:0]    fetch_idx;
  logic [IDXW-1:0]    ex_idx;
  logic [TAGW-1:0]    fetch_tag;
  logic [TAGW-1:0]    ex_tag;
  logic               ex_hit;

  assign fetch_idx   = pc[IDXW+1:2];
  assign fetch_tag   = pc[mbus-1:IDXW+2];
  assign ex_idx      = exPC[IDXW+1:2];
  assign ex_tag      = exPC[mbus-1:IDXW+2];
  assign ex_hit      = valid[ex_idx] && (tag_mem[ex_idx] == ex_tag);
  assign predTaken   = valid[fetch_idx] && (tag_mem[fetch_idx] == fetch_tag) && ctr[fetch_idx][1];
  assign pred_target = target_mem[fetch_idx];
  assign mispredict  = exValid && (taken != exPredTaken);

  // Only taken branches allocate; a not-taken miss leaves the table alone
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr[i]        <= 2'b01;
        tag_mem[i]    <= '0;
        target_mem[i] <= '0;
      end
    end else if (exValid) begin
      if (ex_hit) begin
        if (taken) begin
          if (ctr[ex_idx] != 2'b11) ctr[ex_idx] <= ctr[ex_idx] + 2'b01;
          target_mem[ex_idx] <= exTarget;
        end else if (ctr[ex_idx] != 2'b00) begin
          ctr[ex_idx] <= ctr[ex_idx] - 2'b01;
        end
      end else if (taken) begin
        valid[ex_idx]      <= 1'b1;
        tag_mem[ex_idx]    <= ex_tag;
        target_mem[ex_idx] <= exTarget;
        ctr[ex_idx]        <= 2'b10;
      end
    end
  end
`else
  logic unused_pred;

  // Without a predictor every branch arrives predicted not-taken
  assign predTaken   = 1'b0;
  assign pred_target = '0;
  assign mispredict  = taken;
  assign unused_pred = exPredTaken;
`endif

  // A redirect outranks stall so a flushed pipeline never holds a wrong PC
  always_comb begin
    next_pc = pc + FOUR;
    if (mispredict)     next_pc = taken ? exTarget : (exPC + FOUR);
    else if (stall)     next_pc = pc;
    else if (predTaken) next_pc = pred_target;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc <= RESET_PC;
    else     pc <= next_pc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   mispredictCount <= '0;
    else if (mispredict && !(&mispredictCount)) mispredictCount <= mispredictCount + MCNTW'(1);
  end
endmodule

// File: tb/tb_branch_pc_unit.sv
// Table-driven bench for branch_pc_unit with a next-PC scoreboard queue.
// Predictor-specific sequences run only when BRANCH_PREDICT_EN is defined.
module tb_branch_pc_unit;
  typedef struct packed {
    logic        stall;
    logic        exv;
    logic [31:0] ex_pc;
    logic [31:0] ex_tgt;
    logic [2:0]  cond;
    logic        pred;
    logic [3:0]  cpsr;
    logic        exp_flush;
    logic        exp_pred;
    logic [31:0] exp_pc;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        exValid;
  logic [31:0] exPC;
  logic [31:0] exTarget;
  logic [2:0]  exCond;
  logic        exPredTaken;
  logic [3:0]  CPSR;
  logic [31:0] pc;
  logic        predTaken;
  logic        flush;
  logic [15:0] mispredictCount;
  logic [31:0] pc2;
  logic        pred_taken2;
  logic        flush2;
  logic [1:0]  count2;

  int          passed;
  int          total;
  logic [31:0] sb_pc[$];
  vec_t        vecs[18];

  branch_pc_unit #(.mbus(32), .ENTRIES(16), .RESET_PC(32'h100), .MCNTW(16)) dut (
    .clk(clk), .rst(rst), .stall(stall), .pc(pc), .predTaken(predTaken),
    .exValid(exValid), .exPC(exPC), .exTarget(exTarget), .exCond(exCond),
    .exPredTaken(exPredTaken), .CPSR(CPSR), .flush(flush), .mispredictCount(mispredictCount)
  );

  // Narrow counter copy sharing all stimulus, used to observe saturation
  branch_pc_unit #(.mbus(32), .ENTRIES(16), .RESET_PC(32'h100), .MCNTW(2)) dut2 (
    .clk(clk), .rst(rst), .stall(stall), .pc(pc2), .predTaken(pred_taken2),
    .exValid(exValid), .exPC(exPC), .exTarget(exTarget), .exCond(exCond),
    .exPredTaken(exPredTaken), .CPSR(CPSR), .flush(flush2), .mispredictCount(count2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mkVec(input logic st, input logic v, input logic [31:0] epc,
                                 input logic [31:0] tgt, input logic [2:0] c, input logic p,
                                 input logic [3:0] f, input logic eflush, input logic epred,
                                 input logic [31:0] enext);
    vec_t r;
    r.stall = st; r.exv = v; r.ex_pc = epc; r.ex_tgt = tgt; r.cond = c; r.pred = p;
    r.cpsr = f; r.exp_flush = eflush; r.exp_pred = epred; r.exp_pc = enext;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic driveIdle();
    stall = 1'b0; exValid = 1'b0; exPC = '0; exTarget = '0;
    exCond = 3'b000; exPredTaken = 1'b0; CPSR = 4'b0000;
  endtask

  // Called just after a falling edge; returns at the next falling edge
  task automatic applyStimulus(input vec_t v, input string name);
    logic [31:0] expected;
    stall = v.stall; exValid = v.exv; exPC = v.ex_pc; exTarget = v.ex_tgt;
    exCond = v.cond; exPredTaken = v.pred; CPSR = v.cpsr;
    sb_pc.push_back(v.exp_pc);
    #2;
    checkOutput({name, " flush"}, 32'(flush), 32'(v.exp_flush));
    checkOutput({name, " predTaken"}, 32'(predTaken), 32'(v.exp_pred));
    checkOutput({name, " flush2"}, 32'(flush2), 32'(v.exp_flush));
    checkOutput({name, " predTaken2"}, 32'(pred_taken2), 32'(v.exp_pred));
    @(posedge clk);
    #1;
    if (sb_pc.size() == 0) begin
      total++;
      $display("[TB] FAIL %s scoreboard: got empty queue, expected one entry", name);
    end else begin
      expected = sb_pc.pop_front();
      checkOutput({name, " pc"}, pc, expected);
      checkOutput({name, " pc2"}, pc2, expected);
    end
    @(negedge clk);
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst    = 1'b0;
    driveIdle();

    // CPSR = {V, C, N, Z}
    vecs[0]  = mkVec(0, 0, 32'h0,   32'h0,        3'b000, 0, 4'b0000, 0, 0, 32'h104);
    vecs[1]  = mkVec(0, 0, 32'h0,   32'h0,        3'b000, 0, 4'b0000, 0, 0, 32'h108);
    vecs[2]  = mkVec(0, 1, 32'h20,  32'h80,       3'b001, 0, 4'b0001, 1, 0, 32'h80);
    vecs[3]  = mkVec(1, 0, 32'h0,   32'h0,        3'b000, 0, 4'b0000, 0, 0, 32'h80);
    vecs[4]  = mkVec(1, 1, 32'h24,  32'h200,      3'b010, 0, 4'b0000, 1, 0, 32'h200);
    vecs[5]  = mkVec(0, 1, 32'h40,  32'h300,      3'b011, 0, 4'b0010, 1, 0, 32'h300);
    vecs[6]  = mkVec(0, 1, 32'h44,  32'h400,      3'b100, 0, 4'b1010, 1, 0, 32'h400);
    vecs[7]  = mkVec(0, 1, 32'h2C,  32'h900,      3'b111, 0, 4'b1111, 0, 0, 32'h404);
    vecs[8]  = mkVec(0, 1, 32'h48,  32'h900,      3'b001, 0, 4'b0000, 0, 0, 32'h408);
`ifdef BRANCH_PREDICT_EN
    vecs[9]  = mkVec(0, 1, 32'h500, 32'h900,      3'b001, 1, 4'b0000, 1, 0, 32'h504);
`else
    vecs[9]  = mkVec(0, 1, 32'h500, 32'h900,      3'b001, 1, 4'b0000, 0, 0, 32'h40C);
`endif
    vecs[10] = mkVec(0, 1, 32'h4C,  32'h600,      3'b101, 0, 4'b0100, 1, 0, 32'h600);
    vecs[11] = mkVec(0, 1, 32'h4C,  32'h900,      3'b101, 0, 4'b1011, 0, 0, 32'h604);
    vecs[12] = mkVec(0, 1, 32'h60,  32'h700,      3'b000, 0, 4'b0000, 1, 0, 32'h700);
    vecs[13] = mkVec(0, 1, 32'h64,  32'h900,      3'b110, 0, 4'b1111, 0, 0, 32'h704);
    vecs[14] = mkVec(1, 1, 32'h68,  32'h900,      3'b001, 0, 4'b0000, 0, 0, 32'h704);
    vecs[15] = mkVec(0, 0, 32'h6C,  32'h900,      3'b000, 0, 4'b0000, 0, 0, 32'h708);
    vecs[16] = mkVec(0, 1, 32'h70,  32'hFFFFFFFC, 3'b000, 0, 4'b0000, 1, 0, 32'hFFFFFFFC);
    vecs[17] = mkVec(0, 0, 32'h0,   32'h0,        3'b000, 0, 4'b0000, 0, 0, 32'h0);

    #1 rst = 1'b1;
    #1;
    checkOutput("reset pc", pc, 32'h100);
    checkOutput("reset predTaken", 32'(predTaken), 32'h0);
    checkOutput("reset count", 32'(mispredictCount), 32'h0);
    checkOutput("reset count2", 32'(count2), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

`ifdef BRANCH_PREDICT_EN
    checkOutput("mispredict count", 32'(mispredictCount), 32'd8);
`else
    checkOutput("mispredict count", 32'(mispredictCount), 32'd7);
`endif
    checkOutput("saturated count2", 32'(count2), 32'd3);

    $display("[TB] asserting reset mid-run");
    rst = 1'b1;
    driveIdle();
    #2;
    checkOutput("midrst pc", pc, 32'h100);
    checkOutput("midrst predTaken", 32'(predTaken), 32'h0);
    checkOutput("midrst flush", 32'(flush), 32'h0);
    checkOutput("midrst count", 32'(mispredictCount), 32'h0);
    checkOutput("midrst count2", 32'(count2), 32'h0);
    @(posedge clk);
    #1;
    checkOutput("midrst hold pc", pc, 32'h100);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(mkVec(0, 0, 32'h0, 32'h0, 3'b000, 0, 4'b0000, 0, 0, 32'h104), "post reset 1");
    applyStimulus(mkVec(0, 0, 32'h0, 32'h0, 3'b000, 0, 4'b0000, 0, 0, 32'h108), "post reset 2");

`ifdef BRANCH_PREDICT_EN
    // Cold allocate, warm predict, demote, then saturate the counter at 3
    applyStimulus(mkVec(0, 1, 32'h20,   32'h80, 3'b001, 0, 4'b0001, 1, 0, 32'h80), "cold beq");
    applyStimulus(mkVec(0, 1, 32'h1000, 32'h20, 3'b000, 0, 4'b0000, 1, 0, 32'h20), "jump 0x20 a");
    applyStimulus(mkVec(0, 0, 32'h0,    32'h0,  3'b000, 0, 4'b0000, 0, 1, 32'h80), "warm fetch");
    applyStimulus(mkVec(0, 1, 32'h20,   32'h80, 3'b001, 1, 4'b0000, 1, 0, 32'h24), "warm beq nt");
    applyStimulus(mkVec(0, 1, 32'h1000, 32'h20, 3'b000, 0, 4'b0000, 1, 0, 32'h20), "jump 0x20 b");
    applyStimulus(mkVec(0, 0, 32'h0,    32'h0,  3'b000, 0, 4'b0000, 0, 0, 32'h24), "weak fetch");
    applyStimulus(mkVec(0, 1, 32'h20,   32'h80, 3'b001, 1, 4'b0001, 0, 0, 32'h28), "sat 1");
    applyStimulus(mkVec(0, 1, 32'h20,   32'h80, 3'b001, 1, 4'b0001, 0, 0, 32'h2C), "sat 2");
    applyStimulus(mkVec(0, 1, 32'h20,   32'h80, 3'b001, 1, 4'b0001, 0, 0, 32'h30), "sat 3");
    applyStimulus(mkVec(0, 1, 32'h20,   32'h80, 3'b001, 1, 4'b0001, 0, 0, 32'h34), "sat 4");
    applyStimulus(mkVec(0, 1, 32'h20,   32'h80, 3'b001, 1, 4'b0000, 1, 0, 32'h24), "sat nt");
    applyStimulus(mkVec(0, 1, 32'h1000, 32'h20, 3'b000, 0, 4'b0000, 1, 0, 32'h20), "jump 0x20 c");
    applyStimulus(mkVec(0, 0, 32'h0,    32'h0,  3'b000, 0, 4'b0000, 0, 1, 32'h80), "sat fetch");
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
